// File: rtl/mult_accum_pkg.sv
// Shared constants and types for the multiply-accumulate stage.
package mult_accum_pkg;

  localparam int OPND_W    = 4;   // operand width of the multiplier
  localparam int PROD_W    = 8;   // full product width of a 4x4 multiply
  localparam int ACC_W_DEF = 12;  // default accumulator / result width
  localparam int LEN_DEF   = 4;   // default products per result

  // Term counter; 8 bits covers LEN up to 256.
  typedef logic [7:0] cnt_t;

endpackage

// File: rtl/mult_accum_main.sv
// Combinational 4x4 unsigned multiplier built from shifted partial products.
module main
  import mult_accum_pkg::*;
(
  input  logic [OPND_W-1:0] x,
  input  logic [OPND_W-1:0] y,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] pp [OPND_W];

  // One partial product per multiplier bit: x shifted into place when y[gi] is set.
  for (genvar gi = 0; gi < OPND_W; gi++) begin : g_pp
    assign pp[gi] = y[gi] ? (PROD_W'(x) << gi) : '0;
  end

  // The maximum product is 225, so the 8-bit sum never wraps.
  assign p = pp[0] + pp[1] + pp[2] + pp[3];

endmodule

// File: rtl/mult_accum.sv
// Multiply-accumulate stage: registers operand pairs, multiplies them,
// and emits one dot-product result per LEN terms over valid/ready.
module mult_accum
  import mult_accum_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN   = LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_x,
  input  logic [OPND_W-1:0] in_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic [7:0]        term_cnt
);

  localparam cnt_t LAST_CNT = cnt_t'(LEN - 1);

  // Operand register (S1)
  logic              s1_v;
  logic [OPND_W-1:0] s1_x;
  logic [OPND_W-1:0] s1_y;

  // Accumulation state
  logic [ACC_W-1:0]  acc;
  logic              ovf_acc;
  cnt_t              cnt;

  logic [PROD_W-1:0] p;
  logic [ACC_W:0]    sum;
  logic              last;
  logic              advance;
  logic              xfer;

  main u_mul (
    .x (s1_x),
    .y (s1_y),
    .p (p)
  );

  // The last term may only retire when the output register is free or being drained;
  // in_ready depends on state and out_ready only, never on in_valid.
  assign last     = (cnt == LAST_CNT);
  assign advance  = s1_v && !(last && out_valid && !out_ready);
  assign in_ready = !s1_v || advance;
  assign xfer     = in_valid && in_ready;
  assign sum      = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
  assign term_cnt = cnt;

  // S1 loads on every handshake and empties when its term retires without a refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
    end else if (xfer) begin
      s1_v <= 1'b1;
      s1_x <= in_x;
      s1_y <= in_y;
    end else if (advance) begin
      s1_v <= 1'b0;
    end
  end

  // Accumulator, sticky carry and term counter; cleared when a result is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      ovf_acc <= 1'b0;
      cnt     <= '0;
    end else if (advance) begin
      if (last) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
        cnt     <= '0;
      end else begin
        acc     <= sum[ACC_W-1:0];
        ovf_acc <= ovf_acc | sum[ACC_W];
        cnt     <= cnt + cnt_t'(1);
      end
    end
  end

  // Output register: a new result may replace one being consumed in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (advance && last) begin
      out_valid <= 1'b1;
      out_sum   <= sum[ACC_W-1:0];
      out_ovf   <= ovf_acc | sum[ACC_W];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_accum.sv
// Scoreboard bench: three instances (LEN=4/ACC_W=12, LEN=2/ACC_W=8, LEN=1/ACC_W=12),
// exercised one at a time; a monitor pops expected results on each output handshake.
module tb_mult_accum;

  typedef struct {
    int          inst;
    logic [11:0] sum;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [3];
  logic        ir   [3];
  logic [3:0]  ix   [3];
  logic [3:0]  iy   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [11:0] osum [3];
  logic        oovf [3];
  logic [7:0]  tc   [3];
  logic [7:0]  osum_b;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mult_accum #(.ACC_W(12), .LEN(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_x(ix[0]), .in_y(iy[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(osum[0]), .out_ovf(oovf[0]), .term_cnt(tc[0])
  );

  mult_accum #(.ACC_W(8), .LEN(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_x(ix[1]), .in_y(iy[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(osum_b), .out_ovf(oovf[1]), .term_cnt(tc[1])
  );
  assign osum[1] = {4'b0, osum_b};

  mult_accum #(.ACC_W(12), .LEN(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_x(ix[2]), .in_y(iy[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(osum[2]), .out_ovf(oovf[2]), .term_cnt(tc[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int inst, input logic [11:0] sum, input logic ovf);
    exp_t e;
    e.inst = inst;
    e.sum  = sum;
    e.ovf  = ovf;
    sb.push_back(e);
  endtask

  // Present one pair on instance i starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input int i, input logic [3:0] x, input logic [3:0] y);
    logic ok;
    iv[i] = 1'b1;
    ix[i] = x;
    iy[i] = y;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = ir[i];
      @(posedge clk);
      #1;
      if (ok) begin
        iv[i] = 1'b0;
        $display("inst%0d accepted x=%0d y=%0d", i, x, y);
        return;
      end
    end
    iv[i] = 1'b0;
    check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain_queue_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected result.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i] === 1'b1 && ordy[i] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: inst%0d got sum=%0d, expected none", i, osum[i]);
        end else begin
          mon_e = sb.pop_front();
          $display("inst%0d result sum=%0d ovf=%0d (expected %0d/%0d)",
                   i, osum[i], oovf[i], mon_e.sum, mon_e.ovf);
          check("result_inst", i, mon_e.inst);
          check("result_sum", {20'b0, osum[i]}, {20'b0, mon_e.sum});
          check("result_ovf", {31'b0, oovf[i]}, {31'b0, mon_e.ovf});
        end
      end
    end
  end

  logic       stop_rand;
  logic [7:0] tc_seq[$];

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i]   = 1'b0;
      ix[i]   = '0;
      iy[i]   = '0;
      ordy[i] = 1'b1;
    end
    rst       = 1'b1;
    stop_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", {31'b0, ir[i]}, 1);
      check("rst_out_valid", {31'b0, ov[i]}, 0);
      check("rst_out_sum", {20'b0, osum[i]}, 0);
      check("rst_out_ovf", {31'b0, oovf[i]}, 0);
      check("rst_term_cnt", {24'b0, tc[i]}, 0);
    end
    @(posedge clk);
    #1;

    // Back-to-back dot product: 15+225+0+14 = 254
    push(0, 12'd254, 1'b0);
    send(0, 4'd3, 4'd5);
    send(0, 4'd15, 4'd15);
    send(0, 4'd0, 4'd9);
    send(0, 4'd7, 4'd2);
    @(negedge clk);
    check("s1_valid_before", {31'b0, ov[0]}, 0);
    @(negedge clk);
    check("s1_valid_pulse", {31'b0, ov[0]}, 1);
    @(negedge clk);
    check("s1_valid_after", {31'b0, ov[0]}, 0);
    drain();

    // Same vectors with input bubbles and random output backpressure
    push(0, 12'd254, 1'b0);
    tc_seq.delete();
    fork
      begin
        while (1) begin
          @(posedge clk);
          #1;
          if (stop_rand) break;
          ordy[0] = 1'($urandom_range(0, 1));
        end
      end
      begin
        logic [7:0] prev;
        prev = tc[0];
        while (!stop_rand) begin
          @(negedge clk);
          if (tc[0] !== prev) begin
            tc_seq.push_back(tc[0]);
            prev = tc[0];
          end
        end
      end
    join_none
    begin
      logic [3:0] bx [4];
      logic [3:0] by [4];
      bx = '{4'd3, 4'd15, 4'd0, 4'd7};
      by = '{4'd5, 4'd15, 4'd9, 4'd2};
      for (int t = 0; t < 4; t++) begin
        idle($urandom_range(0, 2));
        send(0, bx[t], by[t]);
      end
    end
    idle(4);
    stop_rand = 1'b1;
    idle(2);
    ordy[0] = 1'b1;
    drain();
    check("bub_tc_len", tc_seq.size(), 4);
    if (tc_seq.size() == 4) begin
      check("bub_tc_0", {24'b0, tc_seq[0]}, 1);
      check("bub_tc_1", {24'b0, tc_seq[1]}, 2);
      check("bub_tc_2", {24'b0, tc_seq[2]}, 3);
      check("bub_tc_3", {24'b0, tc_seq[3]}, 0);
    end

    // Backpressure: 8 x (1,2), output held off
    ordy[0] = 1'b0;
    push(0, 12'd8, 1'b0);
    push(0, 12'd8, 1'b0);
    for (int t = 0; t < 8; t++) send(0, 4'd1, 4'd2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready", {31'b0, ir[0]}, 0);
      check("bp_out_valid", {31'b0, ov[0]}, 1);
      check("bp_out_sum", {20'b0, osum[0]}, 8);
      check("bp_term_cnt", {24'b0, tc[0]}, 3);
    end
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    drain();
    check("bp_out_valid_end", {31'b0, ov[0]}, 0);

    // Reset mid-operation discards a pending result and a partial sum
    ordy[0] = 1'b0;
    for (int t = 0; t < 4; t++) send(0, 4'd1, 4'd1);
    send(0, 4'd15, 4'd15);
    send(0, 4'd15, 4'd15);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", {31'b0, ov[0]}, 0);
    check("mid_rst_term_cnt", {24'b0, tc[0]}, 0);
    check("mid_rst_in_ready", {31'b0, ir[0]}, 1);
    @(posedge clk);
    #1;
    ordy[0] = 1'b1;
    push(0, 12'd4, 1'b0);
    for (int t = 0; t < 4; t++) send(0, 4'd1, 4'd1);
    drain();

    // Overflow on ACC_W=8, LEN=2: 225+225 = 450 -> 194 with carry; then 1+1 = 2
    push(1, 12'd194, 1'b1);
    push(1, 12'd2, 1'b0);
    send(1, 4'd15, 4'd15);
    send(1, 4'd15, 4'd15);
    send(1, 4'd1, 4'd1);
    send(1, 4'd1, 4'd1);
    drain();

    // LEN=1: every pair is its own result
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        push(2, 12'(x * y), 1'b0);
        send(2, 4'(x), 4'(y));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends with a summary.
  initial begin
    #2000000;
    total++;
    bad++;
    $display("FAIL global_timeout: got no finish, expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
